// File: rtl/dipsw_poll_ctrl.sv
// rtl/dipsw_poll_ctrl.sv - DIP-switch PIO poller with edge-capture gating and debounce
// Polls the PIO edge-capture register. On any captured edge it clears the capture, then samples data until stable.
module dipsw_poll_ctrl #(
  parameter int POLL_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata,
  output logic [3:0]  sw_value,
  output logic        sw_valid,
  input  logic        sw_ready,
  output logic        change_irq,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, RD_CAP, CAP_WAIT, CLR, RD_DATA, DATA_WAIT, SETTLE, PRESENT
  } state_t;

  localparam logic [15:0] TICK_LAST  = 16'(POLL_DIV - 1);
  localparam logic [3:0]  STABLE_MIN = 4'(DEBOUNCE_CNT);
  localparam logic [1:0]  ADDR_DATA  = 2'd0;
  localparam logic [1:0]  ADDR_EDGE  = 2'd3;

  state_t      state;
  logic [15:0] tick_cnt;
  logic [3:0]  candidate;
  logic [3:0]  stable_cnt;
  logic [3:0]  last_value;
  logic        delivered;

  logic        tick;
  logic [3:0]  sample;
  logic [3:0]  cand_next;
  logic [3:0]  cnt_next;
  logic        unused_readdata;

  assign tick            = (tick_cnt == TICK_LAST);
  assign sample          = pio_readdata[3:0];
  assign unused_readdata = ^pio_readdata[31:4];

  // A sample only extends the run if it matches the current candidate.
  always_comb begin
    cand_next = sample;
    cnt_next  = 4'd1;
    if (stable_cnt != 4'd0 && sample == candidate) begin
      cand_next = candidate;
      cnt_next  = (stable_cnt == 4'hF) ? 4'hF : stable_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      tick_cnt       <= '0;
      pio_address    <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
      sw_value       <= '0;
      sw_valid       <= 1'b0;
      change_irq     <= 1'b0;
      busy           <= 1'b0;
      candidate      <= '0;
      stable_cnt     <= '0;
      last_value     <= '0;
      delivered      <= 1'b0;
    end else begin
      change_irq <= 1'b0;
      case (state)
        IDLE: begin
          if (!enable) begin
            tick_cnt <= '0;
          end else if (tick) begin
            tick_cnt       <= '0;
            state          <= RD_CAP;
            busy           <= 1'b1;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b1;
            pio_address    <= ADDR_EDGE;
          end else begin
            tick_cnt <= tick_cnt + 16'd1;
          end
        end
        RD_CAP: begin
          state          <= CAP_WAIT;
          pio_chipselect <= 1'b0;
        end
        CAP_WAIT: begin
          if (sample == 4'd0) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tick_cnt <= '0;
          end else begin
            state          <= CLR;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_address    <= ADDR_EDGE;
            pio_writedata  <= '0;
            stable_cnt     <= '0;
          end
        end
        CLR: begin
          state       <= RD_DATA;
          pio_write_n <= 1'b1;
          pio_address <= ADDR_DATA;
        end
        RD_DATA: begin
          state          <= DATA_WAIT;
          pio_chipselect <= 1'b0;
        end
        DATA_WAIT: begin
          candidate  <= cand_next;
          stable_cnt <= cnt_next;
          if (cnt_next < STABLE_MIN) begin
            state    <= SETTLE;
            tick_cnt <= '0;
          end else if (delivered && cand_next == last_value) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tick_cnt <= '0;
          end else begin
            state      <= PRESENT;
            sw_value   <= cand_next;
            sw_valid   <= 1'b1;
            change_irq <= 1'b1;
          end
        end
        SETTLE: begin
          // Once a sequence has started, enable no longer gates the settle tick.
          if (tick) begin
            tick_cnt       <= '0;
            state          <= RD_DATA;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b1;
            pio_address    <= ADDR_DATA;
          end else begin
            tick_cnt <= tick_cnt + 16'd1;
          end
        end
        PRESENT: begin
          if (sw_valid && sw_ready) begin
            sw_valid   <= 1'b0;
            last_value <= sw_value;
            delivered  <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
            tick_cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dipsw_poll_ctrl.sv
// tb/tb_dipsw_poll_ctrl.sv - directed bench for dipsw_poll_ctrl with a behavioural PIO
// The PIO model returns registered read data, latches injected edges and clears them on an edge-register write.
module tb_dipsw_poll_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata = '0;
  logic [3:0]  sw_value;
  logic        sw_valid;
  logic        sw_ready;
  logic        change_irq;
  logic        busy;

  int tests_run = 0;
  int failed = 0;

  logic [3:0] cap_reg = '0;
  logic [3:0] cap_pending;
  logic [3:0] data_arr [0:3];
  int data_len;
  int data_base;
  int rd_total = 0;
  int cyc = 0;

  int n_cs = 0;
  int n_rdcap = 0;
  int n_clr = 0;
  int n_irq = 0;
  int rdcap_gap = 0;
  int last_rdcap = 0;

  dipsw_poll_ctrl #(.POLL_DIV(4), .DEBOUNCE_CNT(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .sw_value       (sw_value),
    .sw_valid       (sw_valid),
    .sw_ready       (sw_ready),
    .change_irq     (change_irq),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    int idx;
    cyc <= cyc + 1;
    if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
      cap_reg <= cap_pending;
    else
      cap_reg <= cap_reg | cap_pending;
    if (pio_chipselect && pio_write_n) begin
      if (pio_address == 2'd3) begin
        pio_readdata <= {28'h0, cap_reg};
      end else if (pio_address == 2'd0) begin
        idx = rd_total - data_base;
        if (idx >= data_len) idx = data_len - 1;
        pio_readdata <= {28'h0, data_arr[idx]};
        rd_total <= rd_total + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (pio_chipselect) n_cs = n_cs + 1;
    if (pio_chipselect && pio_write_n && pio_address == 2'd3) begin
      n_rdcap = n_rdcap + 1;
      rdcap_gap = cyc - last_rdcap;
      last_rdcap = cyc;
    end
    if (pio_chipselect && !pio_write_n && pio_address == 2'd3 && pio_writedata == 32'h0)
      n_clr = n_clr + 1;
    if (change_irq) n_irq = n_irq + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sw_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_cap(input logic [3:0] v);
    cap_pending = v;
    @(negedge clk);
    cap_pending = 4'h0;
  endtask

  task automatic set_data(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2, input int len);
    data_arr[0] = d0;
    data_arr[1] = d1;
    data_arr[2] = d2;
    data_arr[3] = d2;
    data_len = len;
    data_base = rd_total;
  endtask

  task automatic accept;
    sw_ready = 1'b1;
    @(negedge clk);
    sw_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    wait_cycles(3);
    tests_run++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_address !== 2'd0 || pio_writedata !== 32'h0) begin
      failed++;
      $display("FAIL reset_pio: cs=%b wn=%b addr=%0d wd=%0h, required cs=0 wn=1 addr=0 wd=0",
               pio_chipselect, pio_write_n, pio_address, pio_writedata);
    end
    tests_run++;
    if (sw_valid !== 1'b0 || sw_value !== 4'h0 || change_irq !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_out: valid=%b value=%0h irq=%b busy=%b, required all 0",
               sw_valid, sw_value, change_irq, busy);
    end
    reset_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_idle_poll;
    int rc0, clr0;
    enable = 1'b1;
    wait_cycles(20);
    rc0 = n_rdcap;
    clr0 = n_clr;
    wait_cycles(24);
    tests_run++;
    if (n_rdcap - rc0 !== 4) begin
      failed++;
      $display("FAIL idle_rdcap_count: got %0d, required 4", n_rdcap - rc0);
    end
    tests_run++;
    if (rdcap_gap !== 6) begin
      failed++;
      $display("FAIL idle_rdcap_gap: got %0d, required 6", rdcap_gap);
    end
    tests_run++;
    if (n_clr - clr0 !== 0 || sw_valid !== 1'b0) begin
      failed++;
      $display("FAIL idle_quiet: clr=%0d valid=%b, required clr=0 valid=0", n_clr - clr0, sw_valid);
    end
  endtask

  task automatic test_first_offer;
    int clr0, rd0;
    bit ok;
    set_data(4'h5, 4'h5, 4'h5, 1);
    clr0 = n_clr;
    rd0 = rd_total;
    set_cap(4'h1);
    wait_valid(ok);
    tests_run++;
    if (!ok) begin
      failed++;
      $display("FAIL first_offer_timeout: sw_valid=%b, required 1", sw_valid);
    end
    tests_run++;
    if (sw_value !== 4'h5 || change_irq !== 1'b1) begin
      failed++;
      $display("FAIL first_offer_value: value=%0h irq=%b, required value=5 irq=1", sw_value, change_irq);
    end
    tests_run++;
    if (n_clr - clr0 !== 1 || rd_total - rd0 !== 2) begin
      failed++;
      $display("FAIL first_offer_access: clr=%0d reads=%0d, required clr=1 reads=2", n_clr - clr0, rd_total - rd0);
    end
    wait_cycles(1);
    tests_run++;
    if (change_irq !== 1'b0 || sw_valid !== 1'b1) begin
      failed++;
      $display("FAIL first_offer_pulse: irq=%b valid=%b, required irq=0 valid=1", change_irq, sw_valid);
    end
    accept();
    tests_run++;
    if (sw_valid !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL first_offer_accept: valid=%b busy=%b, required 0 0", sw_valid, busy);
    end
  endtask

  task automatic test_restart;
    int rd0;
    bit ok;
    set_data(4'h5, 4'h7, 4'h7, 3);
    rd0 = rd_total;
    set_cap(4'h1);
    wait_valid(ok);
    tests_run++;
    if (!ok || sw_value !== 4'h7) begin
      failed++;
      $display("FAIL restart_value: valid=%b value=%0h, required valid=1 value=7", sw_valid, sw_value);
    end
    tests_run++;
    if (rd_total - rd0 !== 3) begin
      failed++;
      $display("FAIL restart_reads: got %0d, required 3", rd_total - rd0);
    end
    accept();
  endtask

  task automatic test_same_value;
    int clr0, rd0, irq0;
    set_data(4'h7, 4'h7, 4'h7, 1);
    clr0 = n_clr;
    rd0 = rd_total;
    irq0 = n_irq;
    set_cap(4'h2);
    wait_cycles(40);
    tests_run++;
    if (n_clr - clr0 !== 1 || rd_total - rd0 !== 2) begin
      failed++;
      $display("FAIL same_access: clr=%0d reads=%0d, required clr=1 reads=2", n_clr - clr0, rd_total - rd0);
    end
    tests_run++;
    if (n_irq - irq0 !== 0 || sw_valid !== 1'b0) begin
      failed++;
      $display("FAIL same_no_offer: irq=%0d valid=%b, required irq=0 valid=0", n_irq - irq0, sw_valid);
    end
  endtask

  task automatic test_hold;
    int cs0;
    bit ok;
    set_data(4'hA, 4'hA, 4'hA, 1);
    set_cap(4'h4);
    wait_valid(ok);
    tests_run++;
    if (!ok) begin
      failed++;
      $display("FAIL hold_timeout: sw_valid=%b, required 1", sw_valid);
    end
    cs0 = n_cs;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if (sw_valid !== 1'b1 || sw_value !== 4'hA) begin
        failed++;
        $display("FAIL hold_cycle%0d: valid=%b value=%0h, required valid=1 value=a", i, sw_valid, sw_value);
      end
    end
    tests_run++;
    if (n_cs - cs0 !== 0) begin
      failed++;
      $display("FAIL hold_no_pio: got %0d chipselect cycles, required 0", n_cs - cs0);
    end
    accept();
    tests_run++;
    if (sw_valid !== 1'b0) begin
      failed++;
      $display("FAIL hold_release: valid=%b, required 0", sw_valid);
    end
  endtask

  task automatic test_reset_mid;
    int rd0, cs0, waited;
    bit ok;
    set_data(4'hA, 4'hA, 4'hA, 1);
    rd0 = rd_total;
    set_cap(4'h1);
    waited = 0;
    while (rd_total == rd0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    wait_cycles(2);
    tests_run++;
    if (busy !== 1'b1 || waited >= 100) begin
      failed++;
      $display("FAIL mid_settle: busy=%b waited=%0d, required busy=1 waited<100", busy, waited);
    end
    #1 reset_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_address !== 2'd0 || pio_writedata !== 32'h0) begin
      failed++;
      $display("FAIL mid_async_pio: busy=%b cs=%b wn=%b addr=%0d wd=%0h, required 0 0 1 0 0",
               busy, pio_chipselect, pio_write_n, pio_address, pio_writedata);
    end
    tests_run++;
    if (sw_value !== 4'h0 || sw_valid !== 1'b0 || change_irq !== 1'b0) begin
      failed++;
      $display("FAIL mid_async_out: value=%0h valid=%b irq=%b, required 0 0 0", sw_value, sw_valid, change_irq);
    end
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cs0 = n_cs;
    wait_cycles(30);
    tests_run++;
    if (n_cs - cs0 !== 0) begin
      failed++;
      $display("FAIL mid_disabled: got %0d chipselect cycles, required 0", n_cs - cs0);
    end
    enable = 1'b1;
    set_data(4'hA, 4'hA, 4'hA, 1);
    set_cap(4'h1);
    wait_valid(ok);
    tests_run++;
    if (!ok || sw_value !== 4'hA) begin
      failed++;
      $display("FAIL mid_reoffer: valid=%b value=%0h, required valid=1 value=a", sw_valid, sw_value);
    end
    accept();
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    sw_ready = 1'b0;
    cap_pending = 4'h0;
    set_data(4'h0, 4'h0, 4'h0, 1);
    test_reset();
    test_idle_poll();
    test_first_offer();
    test_restart();
    test_same_value();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/dipsw_poll_ctrl.md
DIPSW_POLL_CTRL -- requirements
Module: dipsw_poll_ctrl

Interface
REQ-001 SHALL have parameter POLL_DIV, default 1000, clk cycles between poll/settle ticks (legal range 2..65535).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4, consecutive equal data samples required for a stable value (legal range 1..15).
REQ-003 SHALL have port clk  in  1  system clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  in  1  polling enable.
REQ-006 SHALL have port pio_address  out  2  DIP-switch PIO register address.
REQ-007 SHALL have port pio_chipselect  out  1  PIO select.
REQ-008 SHALL have port pio_write_n  out  1  PIO write strobe, active-low.
REQ-009 SHALL have port pio_writedata  out  32  PIO write data.
REQ-010 SHALL have port pio_readdata  in  32  PIO read data; registered, valid one cycle after the address is driven; bits [3:0] used.
REQ-011 SHALL have port sw_value  out  4  debounced switch value.
REQ-012 SHALL have port sw_valid  out  1  sw_value offered to consumer.
REQ-013 SHALL have port sw_ready  in  1  consumer accepts sw_value.
REQ-014 SHALL have port change_irq  out  1  one-cycle pulse on each new offer.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-016 All outputs SHALL be registered; PIO map: address 0 = data, address 3 = edge capture (write any value clears).
REQ-017 FSM states SHALL be IDLE, RD_CAP, CAP_WAIT, CLR, RD_DATA, DATA_WAIT, SETTLE, PRESENT.
REQ-018 A 16-bit tick counter SHALL run only in IDLE and SETTLE, wrapping POLL_DIV-1 -> 0 with a tick on that cycle; it SHALL clear to 0 on entry to either state.
REQ-019 IDLE: enable=0 SHALL hold counter at 0; tick with enable=1 SHALL go to RD_CAP.
REQ-020 RD_CAP (1 cycle): chipselect=1, write_n=1, address=3; then CAP_WAIT.
REQ-021 CAP_WAIT (1 cycle, chipselect=0): pio_readdata[3:0]==0 -> IDLE; else -> CLR.
REQ-022 CLR (1 cycle): chipselect=1, write_n=0, address=3, writedata=0; also reset stable_cnt=0; then RD_DATA.
REQ-023 RD_DATA (1 cycle): chipselect=1, write_n=1, address=0; then DATA_WAIT.
REQ-024 DATA_WAIT (1 cycle): sample s=pio_readdata[3:0]; if stable_cnt!=0 and s==candidate, stable_cnt+1 (saturating at 15), else candidate=s, stable_cnt=1.
REQ-025 DATA_WAIT: updated stable_cnt < DEBOUNCE_CNT -> SETTLE; else if delivered_flag=1 and candidate==last_value -> IDLE; else -> PRESENT.
REQ-026 SETTLE: tick -> RD_DATA (enable ignored once a sequence started).
REQ-027 PRESENT entry: sw_value=candidate, sw_valid=1, change_irq=1 for exactly the entry cycle.
REQ-028 PRESENT: sw_valid and sw_value SHALL hold stable while sw_ready=0; no PIO access occurs.
REQ-029 sw_valid=1 and sw_ready=1 in same cycle -> next cycle sw_valid=0, last_value=sw_value, delivered_flag=1, state IDLE.
REQ-030 sw_ready while sw_valid=0 SHALL have no effect.
REQ-031 Outside RD_CAP/CLR/RD_DATA, chipselect=0, write_n=1; address/writedata hold last value.
REQ-032 Edges captured by the PIO during SETTLE/PRESENT SHALL be serviced by the next IDLE poll (no loss, no extra state).

Reset
REQ-033 reset_n=0 SHALL force, asynchronously: state IDLE, counter 0, pio_address 0, pio_chipselect 0, pio_write_n 1, pio_writedata 0, sw_value 0, sw_valid 0, change_irq 0, busy 0, candidate 0, stable_cnt 0, last_value 0, delivered_flag 0.
REQ-034 Reset mid-sequence (incl. PRESENT) SHALL abandon it; first post-reset stable value SHALL be offered even if equal to the pre-reset value.

Verification (POLL_DIV=4, DEBOUNCE_CNT=2)
REQ-035 Idle, no edges, enable=1 -> RD_CAP every 4+2 cycles, never CLR, sw_valid stays 0.
REQ-036 Capture reads 0x1, data steady 0x5 -> CLR write addr 3 data 0, two data reads, sw_valid=1 sw_value=0x5, change_irq one cycle.
REQ-037 Data samples 0x5,0x7,0x7 -> candidate restarts at 0x7, offer 0x7 after third read.
REQ-038 Capture 0x2, data stable 0x7 == last_value -> returns to IDLE, no offer, no change_irq.
REQ-039 sw_ready=0 for 20 cycles in PRESENT -> sw_value/sw_valid held, chipselect 0; sw_ready=1 -> sw_valid 0 next cycle.
REQ-040 reset_n pulsed low during SETTLE -> all REQ-033 values immediately; enable=0 afterwards -> no PIO access.
